// File: rtl/csr_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : csr_unit_if
//  Purpose  : CSR access bus between the control unit (master) and the CSR
//             unit (slave): address, operation, write data/mask, read data
//             and the illegal-access flag.
//  Revision : 1.0  initial release
// ============================================================================
interface csr_unit_if #(
  parameter int XLEN = 32
) ();
  logic [11:0]     iCSRAddr;
  logic [1:0]      iCSROp;
  logic [XLEN-1:0] iCSRWData;
  logic [XLEN-1:0] oCSRRData;
  logic            oIllegal;

  modport master (
    output iCSRAddr, iCSROp, iCSRWData,
    input  oCSRRData, oIllegal
  );

  modport slave (
    input  iCSRAddr, iCSROp, iCSRWData,
    output oCSRRData, oIllegal
  );
endinterface
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : csr_unit
//  Purpose  : User-mode CSR file: atomic read/write/set/clear, trap entry and
//             uret sequencing with a registered PC redirect, prioritised
//             interrupt request, free-running cycle/instret counters.
//  Revision : 1.0  initial release
// ============================================================================
module csr_unit #(
  parameter int              XLEN       = 32,
  parameter int              CNT_WIDTH  = 64,
  parameter logic [XLEN-1:0] TVEC_RESET = '0
) (
  input  logic            iCLK,
  input  logic            iRST,
  csr_unit_if.slave       csrBus,
  input  logic            iRetire,
  input  logic            iTrap,
  input  logic [XLEN-1:0] iTrapCause,
  input  logic [XLEN-1:0] iTrapPC,
  input  logic [XLEN-1:0] iTrapVal,
  input  logic            iURet,
  input  logic [1:0]      iIRQ,
  output logic            oIntReq,
  output logic [XLEN-1:0] oIntCause,
  output logic            oRedirect,
  output logic [XLEN-1:0] oPCRedirect
);

  localparam logic [11:0] c_ADDR_USTATUS  = 12'h000;
  localparam logic [11:0] c_ADDR_UIE      = 12'h004;
  localparam logic [11:0] c_ADDR_UTVEC    = 12'h005;
  localparam logic [11:0] c_ADDR_USCRATCH = 12'h040;
  localparam logic [11:0] c_ADDR_UEPC     = 12'h041;
  localparam logic [11:0] c_ADDR_UCAUSE   = 12'h042;
  localparam logic [11:0] c_ADDR_UTVAL    = 12'h043;
  localparam logic [11:0] c_ADDR_UIP      = 12'h044;
  localparam logic [11:0] c_ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] c_ADDR_TIME     = 12'hC01;
  localparam logic [11:0] c_ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] c_ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] c_ADDR_INSTRETH = 12'hC82;

  localparam logic [1:0] c_OP_NONE  = 2'b00;
  localparam logic [1:0] c_OP_WRITE = 2'b01;
  localparam logic [1:0] c_OP_SET   = 2'b10;
  localparam logic [1:0] c_OP_CLEAR = 2'b11;

  localparam bit                   c_HAS_HI  = (CNT_WIDTH > 32);
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    TRAP_RD = 2'd1,
    RET_RD  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic                  r_uieBit;
  logic                  r_upie;
  logic [2:0]            r_uie;       // [2]=bit8 ext, [1]=bit4 timer, [0]=bit0 sw
  logic                  r_usip;
  logic [XLEN-1:0]       r_utvec;
  logic [XLEN-1:0]       r_uscratch;
  logic [XLEN-1:0]       r_uepc;
  logic [XLEN-1:0]       r_ucause;
  logic [XLEN-1:0]       r_utval;
  logic [CNT_WIDTH-1:0]  r_cycle;
  logic [CNT_WIDTH-1:0]  r_instret;
  logic                  r_redirect;
  logic [XLEN-1:0]       r_pcRedirect;

  logic [XLEN-1:0] w_rdata;
  logic            w_impl;
  logic            w_illegal;
  logic [XLEN-1:0] w_newVal;
  logic            w_trapAccept;
  logic            w_retAccept;
  logic            w_csrWrEn;
  logic [2:0]      w_pending;
  logic [3:0]      w_intCode;
  logic [XLEN-1:0] w_intCause;
  logic [XLEN-1:0] w_trapTarget;
  logic            w_redirectNext;
  logic [XLEN-1:0] w_pcNext;
  logic [XLEN-1:0] w_cycleLo;
  logic [XLEN-1:0] w_cycleHi;
  logic [XLEN-1:0] w_instretLo;
  logic [XLEN-1:0] w_instretHi;

  assign w_cycleLo   = XLEN'(r_cycle);
  assign w_instretLo = XLEN'(r_instret);

  // The high-half views only exist when the counters exceed 32 bits.
  generate
    if (c_HAS_HI) begin : g_cntHi
      assign w_cycleHi   = XLEN'(r_cycle[CNT_WIDTH-1:32]);
      assign w_instretHi = XLEN'(r_instret[CNT_WIDTH-1:32]);
    end else begin : g_cntNoHi
      assign w_cycleHi   = '0;
      assign w_instretHi = '0;
    end
  endgenerate

  // Read mux and address decode; reads are pre-update values.
  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (csrBus.iCSRAddr)
      c_ADDR_USTATUS:  w_rdata = XLEN'({r_upie, 3'b000, r_uieBit});
      c_ADDR_UIE:      w_rdata = XLEN'({r_uie[2], 3'b000, r_uie[1], 3'b000, r_uie[0]});
      c_ADDR_UTVEC:    w_rdata = r_utvec;
      c_ADDR_USCRATCH: w_rdata = r_uscratch;
      c_ADDR_UEPC:     w_rdata = r_uepc;
      c_ADDR_UCAUSE:   w_rdata = r_ucause;
      c_ADDR_UTVAL:    w_rdata = r_utval;
      c_ADDR_UIP:      w_rdata = XLEN'({iIRQ[1], 3'b000, iIRQ[0], 3'b000, r_usip});
      c_ADDR_CYCLE,
      c_ADDR_TIME:     w_rdata = w_cycleLo;
      c_ADDR_INSTRET:  w_rdata = w_instretLo;
      c_ADDR_CYCLEH: begin
        if (c_HAS_HI) w_rdata = w_cycleHi;
        else          w_impl  = 1'b0;
      end
      c_ADDR_INSTRETH: begin
        if (c_HAS_HI) w_rdata = w_instretHi;
        else          w_impl  = 1'b0;
      end
      default:         w_impl = 1'b0;
    endcase
  end

  // Counters are read-only: a write, or a set/clear that would change bits, is rejected.
  assign w_illegal = (csrBus.iCSROp != c_OP_NONE) &&
                     (!w_impl ||
                      ((csrBus.iCSRAddr[11:8] == 4'hC) &&
                       ((csrBus.iCSROp == c_OP_WRITE) || (csrBus.iCSRWData != '0))));

  assign csrBus.oCSRRData = w_rdata;
  assign csrBus.oIllegal  = w_illegal;

  // Merge the operand into the current value according to the op.
  always_comb begin
    w_newVal = w_rdata;
    case (csrBus.iCSROp)
      c_OP_WRITE: w_newVal = csrBus.iCSRWData;
      c_OP_SET:   w_newVal = w_rdata | csrBus.iCSRWData;
      c_OP_CLEAR: w_newVal = w_rdata & ~csrBus.iCSRWData;
      default:    w_newVal = w_rdata;
    endcase
  end

  // Trap/uret are only taken in RUN; the redirect cycle is the flush shadow.
  assign w_trapAccept = (r_state == RUN) && iTrap;
  assign w_retAccept  = (r_state == RUN) && iURet && !iTrap;
  assign w_csrWrEn    = (csrBus.iCSROp != c_OP_NONE) && !w_illegal &&
                        !w_trapAccept && !w_retAccept;

  // Interrupt arbitration: external > software > timer, all gated by UIE.
  always_comb begin
    w_pending  = {iIRQ[1], iIRQ[0], r_usip} & r_uie & {3{r_uieBit}};
    w_intCode  = 4'd0;
    w_intCause = '0;
    if (w_pending[2])      w_intCode = 4'd8;
    else if (w_pending[0]) w_intCode = 4'd0;
    else if (w_pending[1]) w_intCode = 4'd4;
    if (w_pending != 3'b000) begin
      w_intCause[XLEN-1] = 1'b1;
      w_intCause[3:0]    = w_intCode;
    end
  end

  assign oIntReq   = (w_pending != 3'b000);
  assign oIntCause = w_intCause;

  // Trap vector: interrupts in vectored mode offset the base by 4*code.
  always_comb begin
    w_trapTarget = {r_utvec[XLEN-1:2], 2'b00};
    if ((r_utvec[1:0] == 2'b01) && iTrapCause[XLEN-1])
      w_trapTarget = {r_utvec[XLEN-1:2], 2'b00} + {iTrapCause[XLEN-3:0], 2'b00};
  end

  // Sequencer next state and next registered redirect outputs.
  always_comb begin
    w_stateNext    = r_state;
    w_redirectNext = 1'b0;
    w_pcNext       = r_pcRedirect;
    case (r_state)
      RUN: begin
        if (w_trapAccept) begin
          w_stateNext    = TRAP_RD;
          w_redirectNext = 1'b1;
          w_pcNext       = w_trapTarget;
        end else if (w_retAccept) begin
          w_stateNext    = RET_RD;
          w_redirectNext = 1'b1;
          w_pcNext       = r_uepc;
        end
      end
      default: w_stateNext = RUN;
    endcase
  end

  // Sequencer state and redirect registers.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state      <= RUN;
      r_redirect   <= 1'b0;
      r_pcRedirect <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_redirect   <= w_redirectNext;
      r_pcRedirect <= w_pcNext;
    end
  end

  assign oRedirect   = r_redirect;
  assign oPCRedirect = r_pcRedirect;

  // CSR storage: trap entry beats uret beats software access; counters always run.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_uieBit   <= 1'b0;
      r_upie     <= 1'b0;
      r_uie      <= 3'b000;
      r_usip     <= 1'b0;
      r_utvec    <= TVEC_RESET;
      r_uscratch <= '0;
      r_uepc     <= '0;
      r_ucause   <= '0;
      r_utval    <= '0;
      r_cycle    <= '0;
      r_instret  <= '0;
    end else begin
      r_cycle <= r_cycle + c_CNT_ONE;
      if (iRetire) r_instret <= r_instret + c_CNT_ONE;
      if (w_trapAccept) begin
        r_uepc   <= {iTrapPC[XLEN-1:2], 2'b00};
        r_ucause <= iTrapCause;
        r_utval  <= iTrapVal;
        r_upie   <= r_uieBit;
        r_uieBit <= 1'b0;
      end else if (w_retAccept) begin
        r_uieBit <= r_upie;
        r_upie   <= 1'b1;
      end else if (w_csrWrEn) begin
        case (csrBus.iCSRAddr)
          c_ADDR_USTATUS: begin
            r_uieBit <= w_newVal[0];
            r_upie   <= w_newVal[4];
          end
          c_ADDR_UIE:      r_uie      <= {w_newVal[8], w_newVal[4], w_newVal[0]};
          c_ADDR_UTVEC:    r_utvec    <= w_newVal;
          c_ADDR_USCRATCH: r_uscratch <= w_newVal;
          c_ADDR_UEPC:     r_uepc     <= {w_newVal[XLEN-1:2], 2'b00};
          c_ADDR_UCAUSE:   r_ucause   <= w_newVal;
          c_ADDR_UTVAL:    r_utval    <= w_newVal;
          c_ADDR_UIP:      r_usip     <= w_newVal[0];
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_unit
//  Purpose  : Directed self-checking bench for csr_unit (64-bit and 8-bit
//             counter builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_csr_unit;

  logic        iCLK = 1'b0;
  logic        iRST, rst8;
  logic        iRetire, retire8, iTrap, iURet;
  logic [31:0] iTrapCause, iTrapPC, iTrapVal;
  logic [1:0]  iIRQ;
  logic        oIntReq, oRedirect, oIntReq8, oRedirect8;
  logic [31:0] oIntCause, oPCRedirect, oIntCause8, oPCRedirect8;

  int nVec = 0;
  int nMis = 0;
  int cycExp = 0;

  // Free-running clock.
  always #5 iCLK = ~iCLK;

  csr_unit_if #(.XLEN(32)) bus  ();
  csr_unit_if #(.XLEN(32)) bus8 ();

  csr_unit #(.XLEN(32), .CNT_WIDTH(64), .TVEC_RESET(32'h0000_0080)) dut (
    .iCLK(iCLK), .iRST(iRST), .csrBus(bus), .iRetire(iRetire),
    .iTrap(iTrap), .iTrapCause(iTrapCause), .iTrapPC(iTrapPC), .iTrapVal(iTrapVal),
    .iURet(iURet), .iIRQ(iIRQ), .oIntReq(oIntReq), .oIntCause(oIntCause),
    .oRedirect(oRedirect), .oPCRedirect(oPCRedirect)
  );

  csr_unit #(.XLEN(32), .CNT_WIDTH(8), .TVEC_RESET(32'h0000_0000)) dut8 (
    .iCLK(iCLK), .iRST(rst8), .csrBus(bus8), .iRetire(retire8),
    .iTrap(iTrap), .iTrapCause(iTrapCause), .iTrapPC(iTrapPC), .iTrapVal(iTrapVal),
    .iURet(iURet), .iIRQ(iIRQ), .oIntReq(oIntReq8), .oIntCause(oIntCause8),
    .oRedirect(oRedirect8), .oPCRedirect(oPCRedirect8)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
    cycExp++;
  endtask

  task automatic op(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
    bus.iCSRAddr = a; bus.iCSROp = o; bus.iCSRWData = d;
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    op(a, 2'b00, 32'h0);
  endtask

  task automatic op8(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
    bus8.iCSRAddr = a; bus8.iCSROp = o; bus8.iCSRWData = d;
    #1;
  endtask

  task automatic test_reset();
    iRST = 1'b1; rst8 = 1'b1;
    tick(); tick();
    iRST = 1'b0; rst8 = 1'b0;
    cycExp = 0;
    rd(12'h005);
    nVec++; if (bus.oCSRRData !== 32'h0000_0080) begin nMis++; $display("FAIL reset_utvec: got %h want %h", bus.oCSRRData, 32'h80); end
    rd(12'h042);
    nVec++; if (bus.oCSRRData !== 32'h0) begin nMis++; $display("FAIL reset_ucause: got %h want 0", bus.oCSRRData); end
    nVec++; if (oRedirect !== 1'b0 || oPCRedirect !== 32'h0) begin nMis++; $display("FAIL reset_redirect: got %b/%h want 0/0", oRedirect, oPCRedirect); end
    rd(12'hC00);
    nVec++; if (bus.oCSRRData !== 32'd0) begin nMis++; $display("FAIL reset_cycle0: got %0d want 0", bus.oCSRRData); end
    tick(); rd(12'hC00);
    nVec++; if (bus.oCSRRData !== 32'd1) begin nMis++; $display("FAIL reset_cycle1: got %0d want 1", bus.oCSRRData); end
    tick(); rd(12'hC00);
    nVec++; if (bus.oCSRRData !== 32'd2) begin nMis++; $display("FAIL reset_cycle2: got %0d want 2", bus.oCSRRData); end
  endtask

  task automatic test_rw();
    op(12'h040, 2'b01, 32'hDEAD_BEEF);
    nVec++; if (bus.oCSRRData !== 32'h0) begin nMis++; $display("FAIL rw_preupdate: got %h want 0", bus.oCSRRData); end
    tick(); rd(12'h040);
    nVec++; if (bus.oCSRRData !== 32'hDEAD_BEEF) begin nMis++; $display("FAIL rw_write: got %h want DEADBEEF", bus.oCSRRData); end
    op(12'h040, 2'b10, 32'h0000_000F); tick(); rd(12'h040);
    nVec++; if (bus.oCSRRData !== 32'hDEAD_BEEF) begin nMis++; $display("FAIL rw_set: got %h want DEADBEEF", bus.oCSRRData); end
    op(12'h040, 2'b11, 32'h0000_00FF); tick(); rd(12'h040);
    nVec++; if (bus.oCSRRData !== 32'hDEAD_BE00) begin nMis++; $display("FAIL rw_clear: got %h want DEADBE00", bus.oCSRRData); end
    op(12'h041, 2'b01, 32'h0000_1003); tick(); rd(12'h041);
    nVec++; if (bus.oCSRRData !== 32'h0000_1000) begin nMis++; $display("FAIL rw_uepc_lsb: got %h want 00001000", bus.oCSRRData); end
  endtask

  task automatic test_trap();
    op(12'h000, 2'b01, 32'h1); tick();
    op(12'h005, 2'b01, 32'h200); tick();
    rd(12'h000);
    iTrap = 1'b1; iTrapCause = 32'd2; iTrapPC = 32'h0040_0012; iTrapVal = 32'h1234;
    tick();
    iTrap = 1'b0;
    nVec++; if (oRedirect !== 1'b1 || oPCRedirect !== 32'h200) begin nMis++; $display("FAIL trap_redirect: got %b/%h want 1/00000200", oRedirect, oPCRedirect); end
    rd(12'h041);
    nVec++; if (bus.oCSRRData !== 32'h0040_0010) begin nMis++; $display("FAIL trap_uepc: got %h want 00400010", bus.oCSRRData); end
    rd(12'h042);
    nVec++; if (bus.oCSRRData !== 32'd2) begin nMis++; $display("FAIL trap_ucause: got %h want 2", bus.oCSRRData); end
    rd(12'h043);
    nVec++; if (bus.oCSRRData !== 32'h1234) begin nMis++; $display("FAIL trap_utval: got %h want 1234", bus.oCSRRData); end
    rd(12'h000);
    nVec++; if (bus.oCSRRData !== 32'h10) begin nMis++; $display("FAIL trap_ustatus: got %h want 10", bus.oCSRRData); end
    tick();
    nVec++; if (oRedirect !== 1'b0) begin nMis++; $display("FAIL trap_pulse_len: got %b want 0", oRedirect); end
  endtask

  task automatic test_vectored();
    op(12'h005, 2'b01, 32'h101); tick();
    op(12'h004, 2'b01, 32'h100); tick();
    rd(12'h000);
    iIRQ = 2'b10; #1;
    nVec++; if (oIntReq !== 1'b0 || oIntCause !== 32'h0) begin nMis++; $display("FAIL irq_gated: got %b/%h want 0/0", oIntReq, oIntCause); end
    op(12'h000, 2'b01, 32'h1); tick(); rd(12'h000);
    nVec++; if (oIntReq !== 1'b1 || oIntCause !== 32'h8000_0008) begin nMis++; $display("FAIL irq_ext: got %b/%h want 1/80000008", oIntReq, oIntCause); end
    iTrap = 1'b1; iTrapCause = 32'h8000_0008; iTrapPC = 32'h0040_0100; iTrapVal = 32'h0;
    tick();
    iTrap = 1'b0;
    nVec++; if (oRedirect !== 1'b1 || oPCRedirect !== 32'h120) begin nMis++; $display("FAIL vec_redirect: got %b/%h want 1/00000120", oRedirect, oPCRedirect); end
    rd(12'h000);
    nVec++; if (bus.oCSRRData !== 32'h10 || oIntReq !== 1'b0) begin nMis++; $display("FAIL vec_ustatus: got %h/%b want 10/0", bus.oCSRRData, oIntReq); end
    tick();
    iURet = 1'b1;
    tick();
    iURet = 1'b0;
    nVec++; if (oRedirect !== 1'b1 || oPCRedirect !== 32'h0040_0100) begin nMis++; $display("FAIL uret_redirect: got %b/%h want 1/00400100", oRedirect, oPCRedirect); end
    rd(12'h000);
    nVec++; if (bus.oCSRRData !== 32'h11 || oIntReq !== 1'b1) begin nMis++; $display("FAIL uret_ustatus: got %h/%b want 11/1", bus.oCSRRData, oIntReq); end
    tick();
    op(12'h004, 2'b01, 32'h111); tick(); rd(12'h000);
    iIRQ = 2'b01; #1;
    nVec++; if (oIntCause !== 32'h8000_0004) begin nMis++; $display("FAIL prio_timer: got %h want 80000004", oIntCause); end
    op(12'h044, 2'b01, 32'h1); tick(); rd(12'h000);
    nVec++; if (oIntCause !== 32'h8000_0000) begin nMis++; $display("FAIL prio_sw: got %h want 80000000", oIntCause); end
    iIRQ = 2'b11; rd(12'h044);
    nVec++; if (oIntCause !== 32'h8000_0008 || bus.oCSRRData !== 32'h111) begin nMis++; $display("FAIL prio_ext_uip: got %h/%h want 80000008/111", oIntCause, bus.oCSRRData); end
    op(12'h044, 2'b01, 32'h0); tick(); rd(12'h044);
    nVec++; if (bus.oCSRRData !== 32'h110) begin nMis++; $display("FAIL uip_ro: got %h want 110", bus.oCSRRData); end
    iIRQ = 2'b00; #1;
    nVec++; if (oIntReq !== 1'b0) begin nMis++; $display("FAIL irq_clear: got %b want 0", oIntReq); end
  endtask

  task automatic test_collisions();
    op(12'h040, 2'b01, 32'h5);
    iTrap = 1'b1; iTrapCause = 32'd2; iTrapPC = 32'h0040_0200; iTrapVal = 32'h0;
    tick();
    iTrap = 1'b0;
    nVec++; if (oRedirect !== 1'b1 || oPCRedirect !== 32'h100) begin nMis++; $display("FAIL coll_redirect: got %b/%h want 1/00000100", oRedirect, oPCRedirect); end
    rd(12'h040);
    nVec++; if (bus.oCSRRData !== 32'hDEAD_BE00) begin nMis++; $display("FAIL coll_dropped_op: got %h want DEADBE00", bus.oCSRRData); end
    iTrap = 1'b1; iTrapPC = 32'h0040_0300;
    op(12'h040, 2'b01, 32'h55);
    tick();
    iTrap = 1'b0;
    nVec++; if (oRedirect !== 1'b0) begin nMis++; $display("FAIL coll_shadow_pulse: got %b want 0", oRedirect); end
    rd(12'h040);
    nVec++; if (bus.oCSRRData !== 32'h55) begin nMis++; $display("FAIL coll_shadow_op: got %h want 55", bus.oCSRRData); end
    rd(12'h041);
    nVec++; if (bus.oCSRRData !== 32'h0040_0200) begin nMis++; $display("FAIL coll_shadow_uepc: got %h want 00400200", bus.oCSRRData); end
    op(12'hC00, 2'b01, 32'h1234_5678);
    nVec++; if (bus.oIllegal !== 1'b1) begin nMis++; $display("FAIL ill_cnt_write: got %b want 1", bus.oIllegal); end
    tick(); rd(12'hC00);
    nVec++; if (bus.oCSRRData !== 32'(cycExp)) begin nMis++; $display("FAIL cnt_unaffected: got %0d want %0d", bus.oCSRRData, cycExp); end
    op(12'hC00, 2'b10, 32'h0);
    nVec++; if (bus.oIllegal !== 1'b0) begin nMis++; $display("FAIL ill_set_zero: got %b want 0", bus.oIllegal); end
    op(12'hC00, 2'b11, 32'h1);
    nVec++; if (bus.oIllegal !== 1'b1) begin nMis++; $display("FAIL ill_clear_mask: got %b want 1", bus.oIllegal); end
    op(12'h7FF, 2'b01, 32'h0);
    nVec++; if (bus.oIllegal !== 1'b1) begin nMis++; $display("FAIL ill_unimpl: got %b want 1", bus.oIllegal); end
    rd(12'h7FF);
    nVec++; if (bus.oIllegal !== 1'b0) begin nMis++; $display("FAIL ill_noop: got %b want 0", bus.oIllegal); end
    rd(12'hC80);
    nVec++; if (bus.oCSRRData !== 32'h0) begin nMis++; $display("FAIL cycleh64: got %h want 0", bus.oCSRRData); end
  endtask

  task automatic test_cnt8();
    rst8 = 1'b1; tick(); rst8 = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    op8(12'hC00, 2'b00, 32'h0);
    nVec++; if (bus8.oCSRRData !== 32'd255) begin nMis++; $display("FAIL cnt8_max: got %0d want 255", bus8.oCSRRData); end
    tick(); op8(12'hC00, 2'b00, 32'h0);
    nVec++; if (bus8.oCSRRData !== 32'd0) begin nMis++; $display("FAIL cnt8_wrap: got %0d want 0", bus8.oCSRRData); end
    op8(12'hC80, 2'b10, 32'h0);
    nVec++; if (bus8.oIllegal !== 1'b1) begin nMis++; $display("FAIL cnt8_cycleh: got %b want 1", bus8.oIllegal); end
    op8(12'hC02, 2'b00, 32'h0);
    retire8 = 1'b1; tick(); tick(); tick(); retire8 = 1'b0; #1;
    nVec++; if (bus8.oCSRRData !== 32'd3) begin nMis++; $display("FAIL cnt8_instret: got %0d want 3", bus8.oCSRRData); end
  endtask

  initial begin
    iRST = 1'b1; rst8 = 1'b1; iRetire = 1'b0; retire8 = 1'b0;
    iTrap = 1'b0; iURet = 1'b0; iIRQ = 2'b00;
    iTrapCause = '0; iTrapPC = '0; iTrapVal = '0;
    bus.iCSRAddr = '0; bus.iCSROp = '0; bus.iCSRWData = '0;
    bus8.iCSRAddr = '0; bus8.iCSROp = '0; bus8.iCSRWData = '0;
    test_reset();
    test_rw();
    test_trap();
    test_vectored();
    test_collisions();
    test_cnt8();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
